// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: font table, segment bit
// positions, parameter limits and the scan sequencer state type.
package seg_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Active-high patterns, bit0 = a .. bit6 = g; b and d are lowercase glyphs.
   localparam logic [6:0] FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam int MIN_DIGITS  = 1;
   localparam int MAX_DIGITS  = 8;
   localparam int MIN_CLK_DIV = 2;
   localparam int MAX_CLK_DIV = 1 << 20;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_hex7seg_font.sv
// Combinational nibble to active-high seven-segment pattern lookup.
module hex7seg_font
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   for (genvar b = SEG_A; b <= SEG_G; b++) begin : g_bit
      assign seg_o[b] = FONT[nib_i][b];
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with ghost blanking,
// leading-zero blanking and frame-synchronous double-buffered update.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYC      = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit LZ_BLANK       = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] din,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_tick
);

   // state   | meaning
   // ST_IDLE | out of reset, outputs inactive; next edge starts slot 0
   // ST_SCAN | counter/index running, outputs track the current slot

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

   if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS ||
       CLK_DIV < MIN_CLK_DIV || CLK_DIV > MAX_CLK_DIV ||
       BLANK_CYC < 0 || BLANK_CYC >= CLK_DIV) begin : g_bad_param
      $error("seg_scan_driver: illegal parameter set");
   end

   scan_state_e state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] pend_din_q, pend_din_d, act_din_q, act_din_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    tick_q, tick_d;

   logic                    frame_start;
   logic                    upper_zero;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [NUM_DIGITS-1:0]   dark;
   logic                    dark_cur;
   logic                    an_on;
   logic [3:0]              nib;
   logic [6:0]              font_pat;
   logic [6:0]              lit_seg;
   logic                    lit_dp;
   logic [NUM_DIGITS-1:0]   an_sel;

   always_comb begin
      state_d = ST_SCAN;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
         end
         ST_SCAN: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d = '0;
               idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign frame_start = (cnt_d == '0) && (idx_d == '0);

   // Pending is updated first so a load on the transfer edge lands in active directly.
   always_comb begin
      pend_din_d = load ? din      : pend_din_q;
      pend_dp_d  = load ? dp_in    : pend_dp_q;
      pend_en_d  = load ? digit_en : pend_en_q;
      act_din_d  = frame_start ? pend_din_d : act_din_q;
      act_dp_d   = frame_start ? pend_dp_d  : act_dp_q;
      act_en_d   = frame_start ? pend_en_d  : act_en_q;
   end

   always_comb begin
      lz_blank   = '0;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         upper_zero  = upper_zero && (act_din_d[4*k +: 4] == 4'h0) && !act_dp_d[k];
         lz_blank[k] = upper_zero;
      end
      dark = ~act_en_d | (LZ_BLANK ? lz_blank : '0);
   end

   assign nib = act_din_d[{idx_d, 2'b00} +: 4];

   hex7seg_font u_font (
      .nib_i (nib),
      .seg_o (font_pat)
   );

   // Outputs are computed from next-state so the registered pins line up with cnt_q/idx_q.
   always_comb begin
      dark_cur = dark[idx_d];
      lit_seg  = dark_cur ? 7'h00 : font_pat;
      lit_dp   = !dark_cur && act_dp_d[idx_d];
      an_on    = int'(cnt_d) >= BLANK_CYC;
      an_sel   = an_on ? (NUM_DIGITS'(1) << idx_d) : '0;
      seg_d    = SEG_ACTIVE_LOW ? ~lit_seg : lit_seg;
      dp_d     = SEG_ACTIVE_LOW ? ~lit_dp  : lit_dp;
      an_d     = AN_ACTIVE_LOW  ? ~an_sel  : an_sel;
      tick_d   = frame_start;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         pend_din_q <= '0;
         pend_dp_q  <= '0;
         pend_en_q  <= '0;
         act_din_q  <= '0;
         act_dp_q   <= '0;
         act_en_q   <= '0;
         seg_q      <= SEG_OFF;
         dp_q       <= DP_OFF;
         an_q       <= AN_OFF;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         pend_din_q <= pend_din_d;
         pend_dp_q  <= pend_dp_d;
         pend_en_q  <= pend_en_d;
         act_din_q  <= act_din_d;
         act_dp_q   <= act_dp_d;
         act_en_q   <= act_en_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         tick_q     <= tick_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign an_out     = an_q;
   assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode or common-cathode seven-segment display. It extends the team's single-digit combinational hex decoder with parametrised digit count, a refresh scan counter, per-digit decimal points and enables, and leading-zero blanking. It also adds an inter-digit ghost-blanking interval and frame-synchronous (tear-free) update of the displayed value. It sits between the system's value registers and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal range 1..8)
CLK_DIV, 50000, clk cycles per digit slot (legal range 2..2^20)
BLANK_CYC, 500, cycles at the start of each slot with all anodes inactive (legal range 0..CLK_DIV-1)
SEG_ACTIVE_LOW, 1, 1 = a segment/dp is lit by driving 0
AN_ACTIVE_LOW, 1, 1 = a digit anode is selected by driving 0
LZ_BLANK, 0, 1 = enable leading-zero blanking

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
din  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 = least significant/rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit
digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit dark
load  in  1  1-cycle strobe: capture din/dp_in/digit_en into pending register
seg_out  out  7  segments, bit0=a .. bit6=g, polarity per SEG_ACTIVE_LOW
dp_out  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an_out  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
frame_tick  out  1  1-cycle pulse on the first cycle of slot 0 of every frame

Behaviour:
- Reset (rst_n low, asynchronous): slot counter=0, digit index=0, pending and active registers=0. All outputs inactive immediately, without waiting for a clock edge: seg_out all unlit, dp_out unlit, an_out all deselected, frame_tick=0.
- Slot timing: counter runs 0..CLK_DIV-1. Digit index advances at wrap: 0,1,..,NUM_DIGITS-1,0. One frame = NUM_DIGITS*CLK_DIV cycles. After reset release, first frame_tick occurs on the first cycle of the first slot-0.
- All outputs are registered. A slot begins on the first cycle an_out could select the new digit.
- Within slot k, cycles 0..BLANK_CYC-1: an_out all deselected; seg_out/dp_out already carry digit k. Cycles BLANK_CYC..CLK_DIV-1: an_out selects only digit k.
- Font, active-high, indexed by nibble: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. b and d are lowercase. With SEG_ACTIVE_LOW=1, seg_out is the bitwise complement.
- Digit k is dark (seg_out and dp_out unlit, anode still scanned) if active digit_en[k]=0 or if k is leading-blanked.
- Leading-zero blanking (LZ_BLANK=1): digit k>0 is blanked if active nibbles k..NUM_DIGITS-1 are all 0 and dp for those digits is 0. Digit 0 is never blanked.
- Double buffering: load captures into pending. Pending copies to active at the clock edge that starts slot 0, which is the frame_tick cycle. A mid-frame load is never visible before the next frame.
- load coincident with the pending-to-active transfer edge: the newly loaded values go straight to active and are displayed in that slot 0.
- Multiple loads within one frame: last one wins.
- Reset mid-scan: aborts the frame. Pending data is lost; the display stays dark until a load and the following frame_tick.

Decomposition:
- Shared package seg_pkg holds the 16-entry active-high font constant array, the segment bit indices (SEG_A..SEG_G), and the parameter legality limits.
- One sub-module, hex7seg_font: combinational nibble-to-7-bit active-high lookup from seg_pkg, instantiated once on the muxed nibble. Polarity inversion stays in seg_scan_driver.
- Counter, index, buffering, blanking and output registers live in seg_scan_driver.

Test Plan:
(Sim parameters: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1, active-low, LZ_BLANK=0 unless noted.)
1. Reset: hold rst_n=0, then release, no load -> seg_out=7'h7F, dp_out=1, an_out=4'hF throughout; frame_tick pulses every 16 cycles.
2. Decode and scan: load din=16'h12AB, digit_en=4'hF, dp_in=4'b0100 -> after next frame_tick, slot 0 shows seg_out=7'h03 with an_out=4'b1110 on slot cycles 1..3. Slot 3 shows seg_out=7'h79 with an_out=4'b0111. dp_out=0 only during slot 2.
3. Ghost blanking: in every slot, cycle 0 has an_out=4'hF while seg_out already holds the new digit's pattern.
4. Leading zeros: LZ_BLANK=1, load din=16'h0050, dp_in=0 -> digits 3 and 2 dark (7'h7F), digit 1 shows 7'h12, digit 0 shows 7'h40. Repeat with din=16'h0000 -> only digit 0 lit, showing 7'h40.
5. Buffering: load 16'h1111 mid-frame, then 16'h2222 two cycles later -> current frame unchanged; next frame shows all digits 7'h24. A load asserted in the frame_tick-producing edge cycle shows its data in that same slot 0.
6. Async reset mid-slot: drop rst_n between clock edges -> outputs go inactive immediately. After release, display stays dark until load and the following frame_tick.
